// File: rtl/vga_pkg.sv
// Shared VGA timing, frame-buffer geometry and small helpers for the
// vga_adapter block.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = 525;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_DEPTH  = 19200;
  localparam int ADDR_W    = 15;
  localparam int COLOUR_W  = 3;

  // Sync/blank bundle carried down the pixel pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  // row*160 + col built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] col,
                                                input logic [6:0] row);
    logic [ADDR_W-1:0] r;
    r = {8'd0, row};
    return (r << 7) + (r << 5) + {7'd0, col};
  endfunction

  function automatic logic [9:0] expand(input logic b);
    return {10{b}};
  endfunction

endpackage

// File: rtl/vga_framebuffer.sv
// 19200x3 simple dual-port frame buffer; read-first when both ports hit the
// same address on one edge.
module vga_framebuffer
  import vga_pkg::*;
#(
  parameter string INIT_FILE = "black.mif"
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [COLOUR_W-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [COLOUR_W-1:0] rdata
);

  if (INIT_FILE == "") begin : g_bad_init
    $error("vga_framebuffer: INIT_FILE must name a background image");
  end

  logic [COLOUR_W-1:0] mem [0:FB_DEPTH-1];

  // Write and read share one process so the read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_adapter.sv
// 160x120 pixel-plotting frame buffer scanned out as 640x480@60 Hz VGA,
// each stored pixel replicated 4x4.
module vga_adapter
  import vga_pkg::*;
#(
  parameter string RESOLUTION              = "160x120",
  parameter string MONOCHROME              = "FALSE",
  parameter int    BITS_PER_COLOUR_CHANNEL = 1,
  parameter string BACKGROUND_IMAGE        = "black.mif"
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic                plot,
  output logic [9:0]          VGA_R,
  output logic [9:0]          VGA_G,
  output logic [9:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK,
  output logic                VGA_SYNC,
  output logic                VGA_CLK
);

  if (RESOLUTION != "160x120") begin : g_bad_res
    $error("vga_adapter: only RESOLUTION \"160x120\" is supported");
  end
  if (BITS_PER_COLOUR_CHANNEL != 1) begin : g_bad_bits
    $error("vga_adapter: only BITS_PER_COLOUR_CHANNEL = 1 is supported");
  end
  if (MONOCHROME != "TRUE" && MONOCHROME != "FALSE") begin : g_bad_mono
    $error("vga_adapter: MONOCHROME must be \"TRUE\" or \"FALSE\"");
  end

  localparam bit        MONO      = (MONOCHROME == "TRUE");
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic                pix;
  logic                pix_en;
  logic [9:0]          hcount;
  logic [9:0]          vcount;
  logic                visible;
  sync_t               sync_now;
  sync_t               sync_s1;
  sync_t               sync_s2;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_waddr;
  logic [ADDR_W-1:0]   fb_raddr;
  logic [COLOUR_W-1:0] fb_rdata;
  logic [9:0]          r_q, g_q, b_q;

  // Pixel clock: clk/2 toggle; the scan moves on the clk edge where pix is high.
  always_ff @(posedge clk) begin
    if (!resetn) pix <= 1'b0;
    else         pix <= ~pix;
  end

  assign pix_en  = pix;
  assign VGA_CLK = pix;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  always_comb begin
    visible        = (hcount < H_VIS) && (vcount < V_VIS);
    sync_now       = SYNC_IDLE;
    sync_now.hs    = !((hcount >= HS_START) && (hcount < HS_END));
    sync_now.vs    = !((vcount >= VS_START) && (vcount < VS_END));
    sync_now.blank = visible;
    // Outside the visible area the address is parked at 0 to stay in range.
    fb_raddr       = visible ? fb_addr(hcount[9:2], vcount[8:2]) : '0;
  end

  always_comb begin
    fb_we    = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
    fb_waddr = fb_addr(x, y);
  end

  vga_framebuffer #(
    .INIT_FILE (BACKGROUND_IMAGE)
  ) u_fb (
    .clk   (clk),
    .we    (fb_we),
    .waddr (fb_waddr),
    .wdata (colour),
    .re    (pix_en),
    .raddr (fb_raddr),
    .rdata (fb_rdata)
  );

  // Stage 1 lines up with the RAM read; stage 2 registers everything to pins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_s1 <= SYNC_IDLE;
      sync_s2 <= SYNC_IDLE;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (pix_en) begin
      sync_s1 <= sync_now;
      sync_s2 <= sync_s1;
      if (sync_s1.blank) begin
        r_q <= expand(MONO ? fb_rdata[0] : fb_rdata[2]);
        g_q <= expand(MONO ? fb_rdata[0] : fb_rdata[1]);
        b_q <= expand(fb_rdata[0]);
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;
  assign VGA_HS    = sync_s2.hs;
  assign VGA_VS    = sync_s2.vs;
  assign VGA_BLANK = sync_s2.blank;
  assign VGA_SYNC  = 1'b1;

endmodule

// File: tb/tb_vga_adapter.sv
// Bench for vga_adapter: reference scan model with an expected queue, a table
// of plotted pixels with fixed screen-point expectations, and hand sequences.
module tb_vga_adapter;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] colour;
  logic [7:0] x;
  logic [6:0] y;
  logic       plot;
  logic [9:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;

  vga_adapter dut (
    .clk       (clk),
    .resetn    (resetn),
    .colour    (colour),
    .x         (x),
    .y         (y),
    .plot      (plot),
    .VGA_R     (vga_r),
    .VGA_G     (vga_g),
    .VGA_B     (vga_b),
    .VGA_HS    (vga_hs),
    .VGA_VS    (vga_vs),
    .VGA_BLANK (vga_blank),
    .VGA_SYNC  (vga_sync),
    .VGA_CLK   (vga_clk)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [2:0] rgb;
    logic [9:0] h;
    logic [9:0] v;
  } exp_t;

  typedef struct {
    int         wx;
    int         wy;
    logic [2:0] wc;
    logic       wp;
    int         chk_h;
    int         chk_v;
    logic [2:0] chk_rgb;
  } vec_t;

  localparam exp_t RESET_EXP = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, rgb: 3'd0, h: 10'd0, v: 10'd0};
  localparam int   N_VEC     = 10;

  vec_t       vecs [N_VEC];
  exp_t       exp_q [$];
  exp_t       last_exp;
  logic [2:0] fbm [FB_DEPTH];
  int         mh, mv;
  int         edge_i;
  int         phase;
  bit         hs_seen;
  int         hs_low_cnt, blank_cnt;
  int         n_cmp, n_err;
  bit         wr_pend;
  int         wr_x, wr_y;
  logic [2:0] wr_c;
  logic       wr_p;

  task automatic check(input string name, input int h, input int v,
                       input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s h=%0d v=%0d: got %0h expected %0h", name, h, v, act, req);
    end
  endtask

  function automatic exp_t model_px(input int h, input int v);
    exp_t e;
    e.h     = 10'(h);
    e.v     = 10'(v);
    e.hs    = !((h >= H_VISIBLE + H_FP) && (h < H_VISIBLE + H_FP + H_SYNC));
    e.vs    = !((v >= V_VISIBLE + V_FP) && (v < V_VISIBLE + V_FP + V_SYNC));
    e.blank = (h < H_VISIBLE) && (v < V_VISIBLE);
    e.rgb   = e.blank ? fbm[(v / 4) * FB_W + h / 4] : 3'd0;
    return e;
  endfunction

  function automatic logic [63:0] pins_of(input exp_t e);
    return {31'd0, e.hs, e.vs, e.blank, {10{e.rgb[2]}}, {10{e.rgb[1]}}, {10{e.rgb[0]}}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_write(input int wx, input int wy, input logic [2:0] wc, input logic wp);
    x       = 8'(wx);
    y       = 7'(wy);
    colour  = wc;
    plot    = wp;
    wr_x    = wx;
    wr_y    = wy;
    wr_c    = wc;
    wr_p    = wp;
    wr_pend = 1'b1;
  endtask

  // One clk: advance the model at the posedge, compare pins at the negedge.
  task automatic step();
    bit           popped;
    logic [63:0]  act;
    @(posedge clk);
    popped = 1'b0;
    if (!resetn) begin
      mh = 0;
      mv = 0;
      edge_i = -1;
      hs_seen = 1'b0;
      exp_q.delete();
      exp_q.push_back(RESET_EXP);
      last_exp = RESET_EXP;
    end else begin
      edge_i++;
      if (edge_i % 2 == 1) begin
        exp_q.push_back(model_px(mh, mv));
        if (mh == H_TOTAL - 1) begin
          mh = 0;
          mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
    if (wr_pend && wr_p && wr_x < FB_W && wr_y < FB_H)
      fbm[wr_y * FB_W + wr_x] = wr_c;
    wr_pend = 1'b0;
    @(negedge clk);
    plot = 1'b0;
    if (resetn && edge_i % 2 == 1) begin
      if (exp_q.size() == 0) begin
        check("queue_underrun", 0, 0, 64'd0, 64'd1);
      end else begin
        last_exp = exp_q.pop_front();
        popped = 1'b1;
      end
    end
    act = {31'd0, vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b};
    check("pins", last_exp.h, last_exp.v, act, pins_of(last_exp));
    check("vga_clk", last_exp.h, last_exp.v, {63'd0, vga_clk},
          {63'd0, (edge_i >= 0 && edge_i % 2 == 0)});
    check("vga_sync", last_exp.h, last_exp.v, {63'd0, vga_sync}, 64'd1);
    if (resetn && !hs_seen && vga_hs == 1'b0) begin
      hs_seen = 1'b1;
      check("first_hs_fall_edge", edge_i, 0, 64'(edge_i), 64'(2 * (H_VISIBLE + H_FP) + 3));
    end
    if (popped) begin
      if (phase == 0 && last_exp.v == 1) begin
        hs_low_cnt += (vga_hs == 1'b0) ? 1 : 0;
        blank_cnt  += (vga_blank == 1'b1) ? 1 : 0;
      end
      for (int k = 0; k < N_VEC; k++) begin
        if (int'(last_exp.h) == vecs[k].chk_h && int'(last_exp.v) == vecs[k].chk_v)
          check($sformatf("table_%0d", k), vecs[k].chk_h, vecs[k].chk_v,
                {34'd0, vga_r, vga_g, vga_b},
                {34'd0, {10{vecs[k].chk_rgb[2]}}, {10{vecs[k].chk_rgb[1]}}, {10{vecs[k].chk_rgb[0]}}});
      end
    end
  endtask

  // Hand-placed writes that land while the scan is running.
  task automatic scan_lines(input int n_lines);
    repeat (2 * H_TOTAL * n_lines) begin
      if (edge_i % 2 == 0) begin
        if (phase == 0 && mv == 2 && mh == 100) drive_write(50, 4, 3'b000, 1'b1);
        if (phase == 0 && mv == 13 && mh == 300) drive_write(60, 3, 3'b111, 1'b1);
        // Lands on the very edge that reads (62,3): old data must come out.
        if (phase == 0 && mv == 14 && mh == 250) drive_write(62, 3, 3'b010, 1'b1);
        if (phase == 1 && mv == 5 && mh % 50 == 0)
          drive_write($urandom_range(0, FB_W - 1), 2, 3'($urandom_range(0, 7)), 1'b1);
      end
      step();
    end
  endtask

  // ---------------- test ----------------
  initial begin
    n_cmp = 0; n_err = 0; phase = 0;
    hs_low_cnt = 0; blank_cnt = 0;
    edge_i = -1; mh = 0; mv = 0; hs_seen = 1'b0;
    wr_pend = 1'b0; wr_p = 1'b0; wr_x = 0; wr_y = 0; wr_c = 3'd0;
    last_exp = RESET_EXP;
    resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
    for (int i = 0; i < FB_DEPTH; i++) fbm[i] = 3'd0;

    //           wx   wy   wc      wp    chk_h chk_v chk_rgb
    vecs[0] = '{ 80,   0, 3'b100, 1'b1, 323,   0, 3'b100};
    vecs[1] = '{159,   1, 3'b111, 1'b1, 639,   7, 3'b111};
    vecs[2] = '{160,   0, 3'b110, 1'b1,   0,   4, 3'b000};
    vecs[3] = '{  3, 120, 3'b101, 1'b1,  12,   0, 3'b000};
    vecs[4] = '{ 10,   2, 3'b010, 1'b0,  40,   8, 3'b000};
    vecs[5] = '{ 40,   3, 3'b011, 1'b1, 160,  12, 3'b011};
    vecs[6] = '{  0,   4, 3'b001, 1'b1,   0,  16, 3'b001};
    vecs[7] = '{ 81,   0, 3'b000, 1'b0, 319,   2, 3'b000};
    vecs[8] = '{  0,   0, 3'b000, 1'b0, 324,   1, 3'b000};
    vecs[9] = '{ 50,   4, 3'b101, 1'b1, 200,  16, 3'b000};

    // Clear the whole buffer through the write port while held in reset.
    for (int a = 0; a < FB_DEPTH; a++) begin
      drive_write(a % FB_W, a / FB_W, 3'b000, 1'b1);
      step();
    end
    for (int k = 0; k < N_VEC; k++) begin
      drive_write(vecs[k].wx, vecs[k].wy, vecs[k].wc, vecs[k].wp);
      step();
    end
    repeat (4) step();

    resetn = 1'b1;
    scan_lines(18);
    check("hs_low_per_line", 0, 1, 64'(hs_low_cnt), 64'(H_SYNC));
    check("blank_high_per_line", 0, 1, 64'(blank_cnt), 64'(H_VISIBLE));
    check("hs_fall_seen_0", 0, 0, {63'd0, hs_seen}, 64'd1);

    // Mid-frame reset: scan restarts at (0,0) and the buffer survives.
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    phase = 1;
    scan_lines(9);
    check("hs_fall_seen_1", 0, 0, {63'd0, hs_seen}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
